// File: rtl/data_mem.sv
// data_mem
//   Byte-wide single-port data memory for the Program 1 converter
//   (fixed-point 8.8 sign-magnitude to float16).
//
//   Program 1 data map:
//     mem_core[0] = int[7:0]                  (operand low byte)
//     mem_core[1] = {sign, int[14:8]}         (operand high byte)
//     mem_core[2] = mant[7:0]                 (result low byte)
//     mem_core[3] = {sign, exp[4:0], mant[9:8]} (result high byte)
//     other addresses are free scratch.
//
//   Ports:
//     clk          single clock, rising-edge active
//     reset        synchronous active-high; only blocks the write in its cycle
//     DataAddress  word address shared by read and write
//     ReadMem      read enable; DataOut is forced to zero while low
//     WriteMem     write enable, sampled at the rising edge
//     DataIn       write data
//     DataOut      combinational read data
//
//   The bench preloads operands and reads results through hierarchical
//   references to mem_core. For that reason the array is an ordinary
//   variable updated from a plain clocked always block, and reset never
//   touches its contents.
module data_mem #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [A-1:0] DataAddress,
  input  logic         ReadMem,
  input  logic         WriteMem,
  input  logic [W-1:0] DataIn,
  output logic [W-1:0] DataOut
);

  localparam int DEPTH = 1 << A;

  logic [W-1:0] mem_core [DEPTH];

  // Zero-latency read with no write bypass: a same-cycle write to the
  // addressed entry shows up only after the capturing edge.
  assign DataOut = ReadMem ? mem_core[DataAddress] : '0;

  // Plain always block so externally deposited values persist until the
  // next internal write to the same entry. Contents are intentionally not
  // reset; preloaded operands must survive a reset pulse.
  always @(posedge clk) begin
    if (!reset && WriteMem) begin
      mem_core[DataAddress] <= DataIn;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] DataAddress;
  logic       ReadMem;
  logic       WriteMem;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  int checks = 0;
  int errors = 0;

  // Reference model: what each byte must hold, and whether it is defined yet.
  logic [7:0] model_mem   [256];
  bit         model_known [256];

  data_mem #(.W(8), .A(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .DataAddress(DataAddress),
    .ReadMem    (ReadMem),
    .WriteMem   (WriteMem),
    .DataIn     (DataIn),
    .DataOut    (DataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end else begin
      $display("ok   %s: %h (t=%0t)", name, got, $time);
    end
  endtask

  // Bench-side deposit straight into the array, mirrored into the model.
  task automatic hier_write(input logic [7:0] addr, input logic [7:0] val);
    dut.mem_core[addr] <= val;
    model_mem[addr]   = val;
    model_known[addr] = 1'b1;
    #1;
  endtask

  // Advance to just after the next falling edge, where inputs are driven.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Model update: a write lands at the edge unless reset is high.
  always @(posedge clk) begin
    if (WriteMem === 1'b1 && reset === 1'b0) begin
      model_mem[DataAddress]   = DataIn;
      model_known[DataAddress] = 1'b1;
    end
  end

  // Continuous compare, once per cycle on the falling edge.
  always @(negedge clk) begin
    if (ReadMem === 1'b0) begin
      check("cyc_readmem_low", DataOut, 8'h00);
    end else if (ReadMem === 1'b1 && model_known[DataAddress]) begin
      check("cyc_read", DataOut, model_mem[DataAddress]);
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) model_known[i] = 1'b0;
    reset       = 1'b1;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataAddress = 8'h00;
    DataIn      = 8'h00;
    step();
    step();
    check("reset_readmem_low", DataOut, 8'h00);
    reset = 1'b0;

    // Hierarchical preload read back without any clock edge.
    step();
    hier_write(8'h01, 8'h81);
    hier_write(8'h00, 8'h80);
    ReadMem = 1'b1;
    DataAddress = 8'h01; #1;
    check("hier_read_1", DataOut, 8'h81);
    DataAddress = 8'h00; #1;
    check("hier_read_0", DataOut, 8'h80);

    // Normal write through the port.
    step();
    DataAddress = 8'h02; DataIn = 8'h3C; WriteMem = 1'b1;
    step();
    WriteMem = 1'b0; #1;
    check("port_write_dout", DataOut, 8'h3C);
    check("port_write_hier", dut.mem_core[2], 8'h3C);

    // Same-cycle read and write at the top address: no bypass.
    step();
    hier_write(8'hFF, 8'h11);
    DataAddress = 8'hFF; DataIn = 8'hA5; WriteMem = 1'b1; #1;
    check("rw_before_edge", DataOut, 8'h11);
    @(posedge clk); #1;
    check("rw_after_edge", DataOut, 8'hA5);
    step();
    WriteMem = 1'b0;

    // Writes during reset are suppressed; preloaded data survives.
    step();
    hier_write(8'h00, 8'h55);
    reset = 1'b1; WriteMem = 1'b1; DataAddress = 8'h00; DataIn = 8'h00;
    step();
    step();
    check("reset_keeps_mem", dut.mem_core[0], 8'h55);
    check("reset_dout_follows", DataOut, 8'h55);
    reset = 1'b0; WriteMem = 1'b0;

    // ReadMem gating is combinational.
    step();
    ReadMem = 1'b0;
    DataAddress = 8'h02; #1;
    check("gate_low_a2", DataOut, 8'h00);
    DataAddress = 8'hFF; #1;
    check("gate_low_aff", DataOut, 8'h00);
    ReadMem = 1'b1; #1;
    check("gate_high_aff", DataOut, 8'hA5);
    DataAddress = 8'h02; #1;
    check("gate_high_a2", DataOut, 8'h3C);

    // Fill the whole array with addr ^ 5A, then read every entry back.
    for (int i = 0; i < 256; i++) begin
      step();
      DataAddress = 8'(i);
      DataIn      = 8'(i) ^ 8'h5A;
      WriteMem    = 1'b1;
    end
    step();
    WriteMem = 1'b0;
    for (int i = 0; i < 256; i++) begin
      DataAddress = 8'(i); #1;
      check($sformatf("fill_%02h", i), DataOut, 8'(i) ^ 8'h5A);
    end
    DataAddress = 8'h00; #1;
    check("fill_a00_lit", DataOut, 8'h5A);
    DataAddress = 8'hFF; #1;
    check("fill_aff_lit", DataOut, 8'hA5);

    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Byte-wide, single-port data memory backing the Program 1 converter (fixed-point 8.8 sign-magnitude to float16). It holds operands and results in a flat 256-entry array. The array is also read and written directly by the bench through hierarchical reference (operand at bytes 1:0, result at bytes 3:2). Reads are combinational; writes are synchronous to the clock.

## Interface
Parameters:
- W, 8, data word width in bits.
- A, 8, address width; depth = 2^A words (256).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- DataAddress  input  A  word address for both read and write.
- ReadMem  input  1  read enable; may be held high permanently.
- WriteMem  input  1  write enable, sampled at rising edge of clk.
- DataIn  input  W  write data.
- DataOut  output  W  read data.

Storage:
- Internal array named mem_core, W bits × 2^A entries, index 0..2^A-1.
- Must remain hierarchically readable and writable by name, element by element (e.g. mem_core[0], mem_core[3]).
- Implemented as a variable written from a plain always block, never a continuous assign, so external hierarchical writes persist until the next internal write to the same entry.

## Operation
- Read: DataOut = mem_core[DataAddress] while ReadMem=1; DataOut = 0 while ReadMem=0. Purely combinational from DataAddress, ReadMem and array contents.
- Write: at the rising edge of clk, if WriteMem=1 and reset=0, then mem_core[DataAddress] <= DataIn. Exactly one entry is written per edge.
- Reset: does not clear or alter mem_core, so operands preloaded before or during reset survive. A write requested while reset=1 is ignored. DataOut has no registered reset value and follows the read rule during reset.
- Power-up contents are undefined (X in simulation) until written internally or by the bench.
- Address is always in range for A=8; no wrap or bounds logic is needed.
- Program 1 data map:
  - mem_core[1] = {sign, int[14:8]}.
  - mem_core[0] = int[7:0].
  - mem_core[3] = {sign, exp[4:0], mant[9:8]}.
  - mem_core[2] = mant[7:0].
  - Other addresses are free scratch.

## Timing
- Read latency: zero cycles. DataOut settles combinationally after any change of DataAddress, ReadMem, or the addressed entry.
- Write latency: one edge. The new value is visible on DataOut immediately after the rising edge that captures it.
- Read and write to the same address in the same cycle: DataOut shows the old value before the edge and the new value after it. No bypass.
- WriteMem and ReadMem both high is legal.
- Hierarchical bench writes take effect immediately and are reflected combinationally on DataOut if addressed.
- Reset mid-operation: contents from all earlier cycles are retained. Only the write in the reset cycle is suppressed.

## Test plan
- Bench writes mem_core[1]=8'h81 and mem_core[0]=8'h80 hierarchically; drive ReadMem=1, DataAddress=1, then 0 -> DataOut=8'h81, then 8'h80 with no clock edge.
- WriteMem=1, DataAddress=8'h02, DataIn=8'h3C, one edge; then WriteMem=0 -> DataOut=8'h3C at address 2, and hierarchical mem_core[2]==8'h3C.
- Same-cycle read/write at address 8'hFF: old value 8'h11, DataIn=8'hA5 -> DataOut=8'h11 before the edge, 8'hA5 after it.
- Preload mem_core[0]=8'h55, then hold reset=1 with WriteMem=1, DataAddress=0, DataIn=8'h00 for two edges -> mem_core[0] still 8'h55.
- ReadMem=0 with any address -> DataOut=8'h00. Raising ReadMem=1 returns the stored byte combinationally.
- Write 256 distinct bytes (addr ^ 8'h5A) at addresses 0..255, then read all back -> every address returns its own value, confirming no aliasing at 8'hFF/8'h00.
